mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port sequencer shared by instruction fetch, load buffer and
// committed stores; serializes multi-byte accesses little-endian.
module mem_arbiter #(
    parameter logic [1:0] IO_MASK = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [5:0]  ld_op,
    input  logic [31:0] ld_addr,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        rob_store_sgn,
    input  logic [5:0]  rob_store_op,
    input  logic [31:0] rob_store_addr,
    input  logic [31:0] rob_store_data,
    output logic        begin_real_store,
    output logic        finish_store
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned CNT_W  = 2;

    localparam logic [OP_W-1:0] OP_LB  = 6'd10;
    localparam logic [OP_W-1:0] OP_LH  = 6'd11;
    localparam logic [OP_W-1:0] OP_LW  = 6'd12;
    localparam logic [OP_W-1:0] OP_LBU = 6'd13;
    localparam logic [OP_W-1:0] OP_LHU = 6'd14;
    localparam logic [OP_W-1:0] OP_SB  = 6'd15;
    localparam logic [OP_W-1:0] OP_SH  = 6'd16;
    localparam logic [OP_W-1:0] OP_SW  = 6'd17;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    // Index of the last byte of an access (length minus one)
    function automatic logic [CNT_W-1:0] op_last(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_last = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_last = 2'd1;
            OP_LW, OP_SW:         op_last = 2'd3;
            default:              op_last = 2'd3;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [OP_W-1:0] op,
                                                    input logic [XLEN-1:0] w);
        case (op)
            OP_LB:   load_extend = {{24{w[7]}}, w[7:0]};
            OP_LH:   load_extend = {{16{w[15]}}, w[15:0]};
            OP_LBU:  load_extend = {24'd0, w[7:0]};
            OP_LHU:  load_extend = {16'd0, w[15:0]};
            default: load_extend = w;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  last_q, last_d;
    logic [XLEN-1:0]   base_q, base_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   xfer_q, xfer_d;
    logic              wr_q, wr_d;
    logic [XLEN-1:0]   mem_a_d;
    logic [BYTE_W-1:0] mem_dout_d;
    logic              if_done_d, ld_done_d, begin_d, finish_d;
    logic [XLEN-1:0]   if_data_d, ld_data_d;

    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   next_addr;
    logic [CNT_W-1:0]  cnt_nx;
    logic              store_io;
    logic              store_ok;

    // Frozen cycles must not repeat a write that is already on the pins
    assign mem_wr = wr_q & rdy;

    always_comb begin
        cnt_nx    = cnt_q + 2'd1;
        next_addr = base_q + XLEN'(cnt_q) + XLEN'(1);
        rd_word   = xfer_q;
        rd_word[{cnt_q, 3'b000} +: BYTE_W] = mem_din;
        store_io  = (rob_store_addr[17:16] == IO_MASK);
        store_ok  = !(store_io && io_buffer_full);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        base_d     = base_q;
        op_d       = op_q;
        xfer_d     = xfer_q;
        wr_d       = wr_q;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        if_done_d  = 1'b0;
        ld_done_d  = 1'b0;
        begin_d    = 1'b0;
        finish_d   = 1'b0;
        if_data_d  = if_data;
        ld_data_d  = ld_data;

        case (state_q)
            S_IDLE: begin
                // A requester whose done pulse is still up is not regranted
                if (rob_store_sgn) begin
                    if (store_ok) begin
                        state_d    = S_STORE;
                        base_d     = rob_store_addr;
                        op_d       = rob_store_op;
                        xfer_d     = rob_store_data;
                        last_d     = op_last(rob_store_op);
                        cnt_d      = '0;
                        mem_a_d    = rob_store_addr;
                        mem_dout_d = rob_store_data[7:0];
                        wr_d       = 1'b1;
                        begin_d    = 1'b1;
                    end
                end else if (rollback) begin
                    state_d = S_IDLE;
                end else if (ld_req && !ld_done) begin
                    state_d = S_LOAD;
                    base_d  = ld_addr;
                    op_d    = ld_op;
                    xfer_d  = '0;
                    last_d  = op_last(ld_op);
                    cnt_d   = '0;
                    mem_a_d = ld_addr;
                end else if (if_req && !if_done) begin
                    state_d = S_FETCH;
                    base_d  = if_addr;
                    op_d    = OP_LW;
                    xfer_d  = '0;
                    last_d  = 2'd3;
                    cnt_d   = '0;
                    mem_a_d = if_addr;
                end
            end
            S_FETCH, S_LOAD: begin
                if (rollback) begin
                    state_d = S_IDLE;
                    xfer_d  = '0;
                end else begin
                    xfer_d  = rd_word;
                    mem_a_d = next_addr;
                    if (cnt_q == last_q) begin
                        state_d = S_IDLE;
                        if (state_q == S_FETCH) begin
                            if_done_d = 1'b1;
                            if_data_d = rd_word;
                        end else begin
                            ld_done_d = 1'b1;
                            ld_data_d = load_extend(op_q, rd_word);
                        end
                    end else begin
                        cnt_d = cnt_nx;
                    end
                end
            end
            S_STORE: begin
                // Committed stores run to completion regardless of rollback
                if (cnt_q == last_q) begin
                    state_d  = S_IDLE;
                    wr_d     = 1'b0;
                    finish_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nx;
                    mem_a_d    = next_addr;
                    mem_dout_d = xfer_q[{cnt_nx, 3'b000} +: BYTE_W];
                end
            end
            default: begin
                state_d = S_IDLE;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            last_q           <= '0;
            base_q           <= '0;
            op_q             <= '0;
            xfer_q           <= '0;
            wr_q             <= 1'b0;
            mem_a            <= '0;
            mem_dout         <= '0;
            if_done          <= 1'b0;
            ld_done          <= 1'b0;
            begin_real_store <= 1'b0;
            finish_store     <= 1'b0;
            if_data          <= '0;
            ld_data          <= '0;
        end else if (rdy) begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_q           <= last_d;
            base_q           <= base_d;
            op_q             <= op_d;
            xfer_q           <= xfer_d;
            wr_q             <= wr_d;
            mem_a            <= mem_a_d;
            mem_dout         <= mem_dout_d;
            if_done          <= if_done_d;
            ld_done          <= ld_done_d;
            begin_real_store <= begin_d;
            finish_store     <= finish_d;
            if_data          <= if_data_d;
            ld_data          <= ld_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a combinational-read byte RAM model and
// hand-computed expectations for each access.
module tb_mem_arbiter;

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ld_req, ld_done;
    logic [5:0]  ld_op;
    logic [31:0] ld_addr, ld_data;
    logic        rob_store_sgn;
    logic [5:0]  rob_store_op;
    logic [31:0] rob_store_addr, rob_store_data;
    logic        begin_real_store, finish_store;

    logic [7:0]  ram [0:1023];
    int          nwr = 0;
    int          wr0;
    int          tests = 0;
    int          fails = 0;

    mem_arbiter #(.IO_MASK(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_op(ld_op), .ld_addr(ld_addr), .ld_done(ld_done),
        .ld_data(ld_data),
        .rob_store_sgn(rob_store_sgn), .rob_store_op(rob_store_op),
        .rob_store_addr(rob_store_addr), .rob_store_data(rob_store_data),
        .begin_real_store(begin_real_store), .finish_store(finish_store)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
            nwr <= nwr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
        ram[10'h110] = 8'h37; ram[10'h111] = 8'h01; ram[10'h112] = 8'h00; ram[10'h113] = 8'h80;
        ram[10'h200] = 8'h80;
        ram[10'h210] = 8'h00; ram[10'h211] = 8'h80;

        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_op = '0; ld_addr = '0;
        rob_store_sgn = 1'b0; rob_store_op = '0; rob_store_addr = '0; rob_store_data = '0;

        step(2);
        check("reset_mem_a", mem_a, 32'h0);
        check("reset_flags", {31'd0, mem_wr} | {30'd0, if_done, ld_done}
                             | {28'd0, begin_real_store, finish_store, 2'b00}, 32'h0);
        rst = 1'b1;
        step();

        // Fetch of 0x100
        if_addr = 32'h100; if_req = 1'b1;
        step(); check("fetch_a0", mem_a, 32'h100);
        step(); check("fetch_a1", mem_a, 32'h101);
        step(); check("fetch_a2", mem_a, 32'h102);
        step(); check("fetch_a3", mem_a, 32'h103);
        check("fetch_not_done_yet", {31'd0, if_done}, 32'd0);
        step(); check("fetch_done", {31'd0, if_done}, 32'd1);
        check("fetch_data", if_data, 32'h00000513);
        if_req = 1'b0;
        step(); check("fetch_done_pulse", {31'd0, if_done}, 32'd0);

        // LB / LBU / LH
        ld_addr = 32'h200; ld_op = OP_LB; ld_req = 1'b1;
        step(); check("lb_a", mem_a, 32'h200);
        step(); check("lb_done", {31'd0, ld_done}, 32'd1);
        check("lb_data", ld_data, 32'hFFFFFF80);
        ld_req = 1'b0;
        step();
        ld_op = OP_LBU; ld_req = 1'b1;
        step(2); check("lbu_done", {31'd0, ld_done}, 32'd1);
        check("lbu_data", ld_data, 32'h00000080);
        ld_req = 1'b0;
        step();
        ld_addr = 32'h210; ld_op = OP_LH; ld_req = 1'b1;
        step(2); check("lh_early", {31'd0, ld_done}, 32'd0);
        step(); check("lh_done", {31'd0, ld_done}, 32'd1);
        check("lh_data", ld_data, 32'hFFFF8000);
        ld_req = 1'b0;
        step();

        // Contention: store, then load, then fetch
        wr0 = nwr;
        if_addr = 32'h110; if_req = 1'b1;
        ld_addr = 32'h200; ld_op = OP_LBU; ld_req = 1'b1;
        rob_store_addr = 32'h300; rob_store_op = OP_SW; rob_store_data = 32'hDEADBEEF;
        rob_store_sgn = 1'b1;
        step(); check("sw_begin", {31'd0, begin_real_store}, 32'd1);
        check("sw_b0", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0300, 8'h01, 8'hEF});
        rob_store_sgn = 1'b0;
        step(); check("sw_begin_pulse", {31'd0, begin_real_store}, 32'd0);
        check("sw_b1", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0301, 8'h01, 8'hBE});
        step(); check("sw_b2", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0302, 8'h01, 8'hAD});
        step(); check("sw_b3", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0303, 8'h01, 8'hDE});
        step(); check("sw_finish", {30'd0, finish_store, mem_wr}, 32'd2);
        step(); check("cont_load_grant", mem_a, 32'h200);
        check("cont_finish_pulse", {31'd0, finish_store}, 32'd0);
        step(); check("cont_ld_done", {31'd0, ld_done}, 32'd1);
        check("cont_ld_data", ld_data, 32'h00000080);
        ld_req = 1'b0;
        step(); check("cont_fetch_grant", mem_a, 32'h110);
        step(3); check("cont_fetch_wait", {31'd0, if_done}, 32'd0);
        step(); check("cont_if_done", {31'd0, if_done}, 32'd1);
        check("cont_if_data", if_data, 32'h80000137);
        if_req = 1'b0;
        check("sw_ram", {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}, 32'hDEADBEEF);
        check("sw_nwr", 32'(nwr - wr0), 32'd4);
        step();

        // Rollback during the 2nd byte of a fetch
        if_addr = 32'h100; if_req = 1'b1;
        step(2); check("rb_fetch_a1", mem_a, 32'h101);
        rollback = 1'b1; if_req = 1'b0;
        step(); check("rb_fetch_no_done", {31'd0, if_done}, 32'd0);
        rollback = 1'b0;
        ld_addr = 32'h200; ld_op = OP_LB; ld_req = 1'b1;
        step(); check("rb_fetch_idle", mem_a, 32'h200);
        check("rb_fetch_no_done2", {31'd0, if_done}, 32'd0);
        step(); check("rb_ld_done", {31'd0, ld_done}, 32'd1);
        ld_req = 1'b0;
        step();

        // Rollback during SH: store completes
        wr0 = nwr;
        rob_store_addr = 32'h320; rob_store_op = OP_SH; rob_store_data = 32'h1234A5B6;
        rob_store_sgn = 1'b1;
        step(); check("sh_begin", {31'd0, begin_real_store}, 32'd1);
        rob_store_sgn = 1'b0; rollback = 1'b1;
        step(); check("sh_b1", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0321, 8'h01, 8'hA5});
        step(); check("sh_finish", {30'd0, finish_store, mem_wr}, 32'd2);
        rollback = 1'b0;
        check("sh_ram", {16'd0, ram[10'h321], ram[10'h320]}, 32'h0000A5B6);
        check("sh_nwr", 32'(nwr - wr0), 32'd2);
        step();

        // Rollback in IDLE blocks a load grant for that edge
        ld_addr = 32'h200; ld_op = OP_LB; ld_req = 1'b1; rollback = 1'b1;
        step(); rollback = 1'b0;
        step(); check("rb_idle_no_grant", {31'd0, ld_done}, 32'd0);
        step(); check("rb_idle_late_done", {31'd0, ld_done}, 32'd1);
        ld_req = 1'b0;
        step();

        // I/O store stalled while the buffer is full; load must not slip in
        wr0 = nwr;
        rob_store_addr = 32'h00030000; rob_store_op = OP_SB; rob_store_data = 32'h00000077;
        rob_store_sgn = 1'b1; io_buffer_full = 1'b1;
        ld_addr = 32'h200; ld_op = OP_LB; ld_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("io_stall_%0d", i),
                  {29'd0, mem_wr, begin_real_store, ld_done}, 32'd0);
        end
        io_buffer_full = 1'b0;
        step(); check("io_begin", {30'd0, begin_real_store, mem_wr}, 32'd3);
        check("io_addr", mem_a, 32'h00030000);
        check("io_dout", {24'd0, mem_dout}, 32'h77);
        rob_store_sgn = 1'b0;
        step(); check("io_finish", {31'd0, finish_store}, 32'd1);
        check("io_ram", {24'd0, ram[0]}, 32'h77);
        check("io_nwr", 32'(nwr - wr0), 32'd1);
        step(); check("io_then_load", mem_a, 32'h200);
        step(); check("io_ld_done", {31'd0, ld_done}, 32'd1);
        ld_req = 1'b0;
        step();

        // Freeze mid-SW
        wr0 = nwr;
        rob_store_addr = 32'h340; rob_store_op = OP_SW; rob_store_data = 32'h11223344;
        rob_store_sgn = 1'b1;
        step(); rob_store_sgn = 1'b0; rdy = 1'b0;
        #1; check("frz_wr_pin", {31'd0, mem_wr}, 32'd0);
        step(2); check("frz_begin_held", {31'd0, begin_real_store}, 32'd1);
        check("frz_a_held", mem_a, 32'h340);
        check("frz_no_write", 32'(nwr - wr0), 32'd0);
        rdy = 1'b1;
        #1; check("frz_wr_resume", {31'd0, mem_wr}, 32'd1);
        step(); check("frz_b1", {mem_a[15:0], 7'd0, begin_real_store, mem_dout}, {16'h0341, 8'h00, 8'h33});
        step(2); check("frz_b3", {mem_a[15:0], 8'd0, mem_dout}, {16'h0343, 8'h00, 8'h11});
        step(); check("frz_finish", {31'd0, finish_store}, 32'd1);
        check("frz_ram", {ram[10'h343], ram[10'h342], ram[10'h341], ram[10'h340]}, 32'h11223344);
        check("frz_nwr", 32'(nwr - wr0), 32'd4);
        step();

        // Reset mid-SW
        rob_store_addr = 32'h360; rob_store_op = OP_SW; rob_store_data = 32'hCAFEF00D;
        rob_store_sgn = 1'b1;
        step(); rob_store_sgn = 1'b0;
        step(); #2; rst = 1'b0;
        #1;
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_dout_wr", {23'd0, mem_wr, mem_dout}, 32'h0);
        check("rst_pulses", {28'd0, begin_real_store, finish_store, if_done, ld_done}, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_ld_data", ld_data, 32'h0);
        step(); rst = 1'b1;
        ld_addr = 32'h200; ld_op = OP_LB; ld_req = 1'b1;
        step(); check("post_rst_grant", mem_a, 32'h200);
        step(); check("post_rst_ld", ld_data, 32'hFFFFFF80);
        check("post_rst_done", {31'd0, ld_done}, 32'd1);
        ld_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
